// File: rtl/c2h_dma_pkg.sv
// Shared types and helpers for the C2H frame fetch path: FSM encoding,
// beat/keep arithmetic and the width of the metadata word that rides with each beat.
package c2h_dma_pkg;

  localparam int BYTES     = 512 / 8;
  localparam int MAX_BYTES = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  // {last, keep, tag, len} as stored in the skid FIFO
  function automatic int meta_width(input int keep_w, input int tag_w, input int len_w);
    return 1 + keep_w + tag_w + len_w;
  endfunction

  function automatic int unsigned beats_of(input int unsigned len, input int unsigned bytes);
    return (len + bytes - 1) / bytes;
  endfunction

  function automatic logic [MAX_BYTES-1:0] last_keep(input int unsigned len,
                                                     input int unsigned bytes);
    int unsigned rem;
    rem = len % bytes;
    if (rem == 0) return {MAX_BYTES{1'b1}} >> (MAX_BYTES - bytes);
    return (MAX_BYTES'(1) << rem) - MAX_BYTES'(1);
  endfunction

endpackage

// File: rtl/c2h_fetch_skid_fifo.sv
// First-word-fall-through skid FIFO with flop storage; head word is presented
// the cycle after it is written and forced to zero while the FIFO is empty.
module c2h_fetch_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop;

  assign rd_valid = (count_q != '0);
  assign pop      = rd_en && rd_valid;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // The fetch side only reserves space it knows it has; a write into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && !pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/c2h_frame_fetch.sv
// Pulls frames from the C2H frame source beat by beat, realigns the source's
// fixed data latency with per-beat metadata, and re-emits them as AXI-stream.
module c2h_frame_fetch
  import c2h_dma_pkg::*;
#(
  parameter int FRAME_DATA_WIDTH = 512,
  parameter int LEN_WIDTH        = 16,
  parameter int TAG_WIDTH        = 8,
  parameter int FRAME_PIPELINE   = 1,
  parameter int SKID_DEPTH       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          read_frame_enb,
  input  logic [FRAME_DATA_WIDTH-1:0]   read_frame_tdata,
  input  logic                          read_frame_ready,
  input  logic [LEN_WIDTH-1:0]          read_frame_len,
  input  logic [TAG_WIDTH-1:0]          read_frame_tag,
  output logic [FRAME_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [FRAME_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [TAG_WIDTH-1:0]          m_axis_tid,
  output logic [LEN_WIDTH-1:0]          m_axis_tdest,
  output logic                          status_frame_done,
  output logic                          status_len_err,
  output logic [31:0]                   frame_cnt
);

  localparam int NB = FRAME_DATA_WIDTH / 8;
  localparam int MW = meta_width(NB, TAG_WIDTH, LEN_WIDTH);
  localparam int FW = FRAME_DATA_WIDTH + MW;
  localparam int CW = $clog2(SKID_DEPTH) + 1;
  localparam int BW = LEN_WIDTH + 1;
  localparam logic [BW-1:0] ONE_BEAT = BW'(1);

  fetch_state_e          state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [BW-1:0]         rem_q, rem_d;
  logic                  discard_q, discard_d;
  logic                  len_err_q, len_err_d;
  logic [31:0]           frame_cnt_q, frame_cnt_d;

  logic                  enb;
  logic                  room;
  logic                  enb_last;
  logic [NB-1:0]         enb_keep;
  logic [MW:0]           enb_meta;
  logic                  st_vld;
  logic [MW:0]           st_meta;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_wr;
  logic [FW-1:0]         fifo_rdata;
  logic                  fifo_valid;
  logic                  hs_last;

  // Reserve a FIFO slot for every beat already requested but not yet landed.
  assign room = (int'(fifo_count) + int'(inflight) + 1) <= SKID_DEPTH;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    tag_d     = tag_q;
    rem_d     = rem_q;
    discard_d = discard_q;
    len_err_d = 1'b0;
    enb       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_frame_ready) begin
          len_d     = read_frame_len;
          tag_d     = read_frame_tag;
          discard_d = (read_frame_len == '0);
          len_err_d = (read_frame_len == '0);
          rem_d     = (read_frame_len == '0) ? ONE_BEAT
                                             : BW'(beats_of(32'(read_frame_len), NB));
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (read_frame_ready && room) begin
          enb   = 1'b1;
          rem_d = rem_q - ONE_BEAT;
          if (rem_q == ONE_BEAT) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enb_last = (rem_q == ONE_BEAT);
  assign enb_keep = enb_last ? NB'(last_keep(32'(len_q), NB)) : '1;
  assign enb_meta = {discard_q, enb_last, enb_keep, tag_q, len_q};
  assign read_frame_enb = enb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      tag_q       <= '0;
      rem_q       <= '0;
      discard_q   <= 1'b0;
      len_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tag_q       <= tag_d;
      rem_q       <= rem_d;
      discard_q   <= discard_d;
      len_err_q   <= len_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Metadata delay line matching the source's data latency
  if (FRAME_PIPELINE == 0) begin : g_nopipe
    assign st_vld   = enb;
    assign st_meta  = enb_meta;
    assign inflight = '0;
  end else begin : g_pipe
    logic [FRAME_PIPELINE-1:0] vld_q, vld_d;
    logic [MW:0]               meta_q [FRAME_PIPELINE];
    logic [MW:0]               meta_d [FRAME_PIPELINE];

    always_comb begin
      vld_d[0]  = enb;
      meta_d[0] = enb_meta;
      for (int i = 1; i < FRAME_PIPELINE; i++) begin
        vld_d[i]  = vld_q[i-1];
        meta_d[i] = meta_q[i-1];
      end
      inflight = '0;
      for (int i = 0; i < FRAME_PIPELINE; i++) inflight = inflight + CW'(vld_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
    end

    always_ff @(posedge clk) meta_q <= meta_d;

    assign st_vld  = vld_q[FRAME_PIPELINE-1];
    assign st_meta = meta_q[FRAME_PIPELINE-1];
  end

  // Skid FIFO and AXI-stream output
  assign fifo_wr = st_vld && !st_meta[MW];

  c2h_fetch_skid_fifo #(
    .WIDTH (FW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (fifo_wr),
    .wr_data  ({read_frame_tdata, st_meta[MW-1:0]}),
    .rd_en    (m_axis_tready),
    .rd_data  (fifo_rdata),
    .rd_valid (fifo_valid),
    .count    (fifo_count)
  );

  assign {m_axis_tdata, m_axis_tlast, m_axis_tkeep, m_axis_tid, m_axis_tdest} = fifo_rdata;
  assign m_axis_tvalid = fifo_valid;

  assign hs_last           = fifo_valid && m_axis_tready && m_axis_tlast;
  assign frame_cnt_d       = hs_last ? frame_cnt_q + 32'd1 : frame_cnt_q;
  assign status_frame_done = hs_last;
  assign status_len_err    = len_err_q;
  assign frame_cnt         = frame_cnt_q;

endmodule

// File: tb/tb_c2h_frame_fetch.sv
// Directed bench for c2h_frame_fetch: a latency-1 frame source with a beat counter
// data pattern feeds the DUT while a monitor records every m_axis handshake.
module tb_c2h_frame_fetch;

  localparam int W  = 512;
  localparam int NB = 64;
  localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct { int len; int tag; } frame_t;
  typedef struct {
    logic [W-1:0]  data;
    logic [NB-1:0] keep;
    logic          last;
    logic [7:0]    tid;
    logic [15:0]   tdest;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read_frame_enb;
  logic [W-1:0]  read_frame_tdata;
  logic          read_frame_ready;
  logic [15:0]   read_frame_len;
  logic [7:0]    read_frame_tag;
  logic [W-1:0]  m_axis_tdata;
  logic [NB-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [7:0]    m_axis_tid;
  logic [15:0]   m_axis_tdest;
  logic          status_frame_done;
  logic          status_len_err;
  logic [31:0]   frame_cnt;

  c2h_frame_fetch #(
    .FRAME_DATA_WIDTH (W),
    .LEN_WIDTH        (16),
    .TAG_WIDTH        (8),
    .FRAME_PIPELINE   (1),
    .SKID_DEPTH       (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .read_frame_enb    (read_frame_enb),
    .read_frame_tdata  (read_frame_tdata),
    .read_frame_ready  (read_frame_ready),
    .read_frame_len    (read_frame_len),
    .read_frame_tag    (read_frame_tag),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tid        (m_axis_tid),
    .m_axis_tdest      (m_axis_tdest),
    .status_frame_done (status_frame_done),
    .status_len_err    (status_len_err),
    .frame_cnt         (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input int unsigned c);
    return {16{c}};
  endfunction

  function automatic int beats(input int len);
    return (len == 0) ? 1 : (len + NB - 1) / NB;
  endfunction

  // Frame source: one-cycle data latency, beat counter pattern, frames from frame_q
  frame_t      frame_q[$];
  int          src_idx;
  logic        src_active;
  int          src_left;
  int unsigned src_ctr;
  logic        hold = 1'b0;

  assign read_frame_ready = src_active && !hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_active       <= 1'b0;
      src_left         <= 0;
      src_ctr          <= 0;
      src_idx          <= frame_q.size();
      read_frame_tdata <= '0;
      read_frame_len   <= '0;
      read_frame_tag   <= '0;
    end else if (read_frame_enb) begin
      read_frame_tdata <= pat(src_ctr);
      src_ctr          <= src_ctr + 1;
      src_left         <= src_left - 1;
      if (src_left == 1) src_active <= 1'b0;
    end else if (!src_active && src_idx < frame_q.size()) begin
      read_frame_len <= 16'(frame_q[src_idx].len);
      read_frame_tag <= 8'(frame_q[src_idx].tag);
      src_left       <= beats(frame_q[src_idx].len);
      src_active     <= 1'b1;
      src_idx        <= src_idx + 1;
    end
  end

  beat_t mon_q[$];
  int    enb_cnt  = 0;
  int    done_cnt = 0;
  int    lerr_cnt = 0;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready)
      mon_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest});
    if (read_frame_enb)    enb_cnt  <= enb_cnt + 1;
    if (status_frame_done) done_cnt <= done_cnt + 1;
    if (status_len_err)    lerr_cnt <= lerr_cnt + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_beats(input string tag, input int base, input int n, input int budget);
    int c;
    c = 0;
    while (mon_q.size() - base < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(tag, W'(mon_q.size() - base >= n), W'(1));
  endtask

  task automatic wait_enb(input string tag, input int base, input int n, input int budget);
    int c;
    c = 0;
    while (enb_cnt - base < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check(tag, W'(enb_cnt - base >= n), W'(1));
  endtask

  initial begin
    int b0, e0, eh, nl;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", W'(m_axis_tvalid), W'(0));
    check("rst_tlast",  W'(m_axis_tlast), W'(0));
    check("rst_tdata",  m_axis_tdata, W'(0));
    check("rst_tkeep",  W'(m_axis_tkeep), W'(0));
    check("rst_enb",    W'(read_frame_enb), W'(0));
    check("rst_cnt",    W'(frame_cnt), W'(0));
    check("rst_lerr",   W'(status_len_err), W'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single full beat
    b0 = mon_q.size(); e0 = enb_cnt;
    frame_q.push_back('{64, 8'h05});
    wait_beats("t1_wait", b0, 1, 50);
    check("t1_nbeats", W'(mon_q.size() - b0), W'(1));
    check("t1_enb",    W'(enb_cnt - e0), W'(1));
    check("t1_data",   mon_q[b0].data, pat(0));
    check("t1_keep",   W'(mon_q[b0].keep), W'(KEEP_ALL));
    check("t1_last",   W'(mon_q[b0].last), W'(1));
    check("t1_tid",    W'(mon_q[b0].tid), W'(8'h05));
    check("t1_tdest",  W'(mon_q[b0].tdest), W'(64));
    check("t1_done",   W'(done_cnt), W'(1));
    check("t1_cnt",    W'(frame_cnt), W'(1));

    // 2: partial last beat
    b0 = mon_q.size(); e0 = enb_cnt;
    frame_q.push_back('{130, 8'h22});
    wait_beats("t2_wait", b0, 3, 50);
    check("t2_nbeats", W'(mon_q.size() - b0), W'(3));
    check("t2_enb",    W'(enb_cnt - e0), W'(3));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_data%0d", i),  mon_q[b0+i].data, pat(1 + i));
      check($sformatf("t2_keep%0d", i),  W'(mon_q[b0+i].keep), (i == 2) ? W'(64'h3) : W'(KEEP_ALL));
      check($sformatf("t2_last%0d", i),  W'(mon_q[b0+i].last), W'(i == 2));
      check($sformatf("t2_tdest%0d", i), W'(mon_q[b0+i].tdest), W'(130));
      check($sformatf("t2_tid%0d", i),   W'(mon_q[b0+i].tid), W'(8'h22));
    end
    check("t2_cnt", W'(frame_cnt), W'(2));

    // 3: backpressure limits outstanding beats to the skid depth
    b0 = mon_q.size(); e0 = enb_cnt;
    m_axis_tready = 1'b0;
    frame_q.push_back('{2048, 8'h33});
    repeat (40) @(posedge clk);
    #1;
    check("t3_enb_stall", W'(enb_cnt - e0), W'(8));
    check("t3_no_beats",  W'(mon_q.size() - b0), W'(0));
    check("t3_tvalid",    W'(m_axis_tvalid), W'(1));
    check("t3_head",      m_axis_tdata, pat(4));
    m_axis_tready = 1'b1;
    wait_beats("t3_wait", b0, 32, 200);
    check("t3_nbeats", W'(mon_q.size() - b0), W'(32));
    check("t3_enb",    W'(enb_cnt - e0), W'(32));
    for (int i = 0; i < 32; i++) begin
      check($sformatf("t3_data%0d", i), mon_q[b0+i].data, pat(4 + i));
      check($sformatf("t3_last%0d", i), W'(mon_q[b0+i].last), W'(i == 31));
    end
    check("t3_keep_last", W'(mon_q[b0+31].keep), W'(KEEP_ALL));
    check("t3_cnt", W'(frame_cnt), W'(3));

    // 4: source drops ready mid-frame
    b0 = mon_q.size(); e0 = enb_cnt;
    frame_q.push_back('{512, 8'h44});
    wait_enb("t4_wait_enb", e0, 3, 50);
    #1 hold = 1'b1;
    #1;
    check("t4_enb_low", W'(read_frame_enb), W'(0));
    eh = enb_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("t4_gap", W'(enb_cnt - eh), W'(0));
    hold = 1'b0;
    wait_beats("t4_wait", b0, 8, 100);
    check("t4_nbeats", W'(mon_q.size() - b0), W'(8));
    nl = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_data%0d", i), mon_q[b0+i].data, pat(36 + i));
      nl += int'(mon_q[b0+i].last);
    end
    check("t4_nlast",  W'(nl), W'(1));
    check("t4_last7",  W'(mon_q[b0+7].last), W'(1));
    check("t4_cnt",    W'(frame_cnt), W'(4));

    // 5: zero-length frame is fetched and dropped, next frame unaffected
    b0 = mon_q.size(); e0 = enb_cnt;
    frame_q.push_back('{0, 8'h55});
    repeat (15) @(posedge clk);
    #1;
    check("t5_lerr",     W'(lerr_cnt), W'(1));
    check("t5_enb",      W'(enb_cnt - e0), W'(1));
    check("t5_no_beat",  W'(mon_q.size() - b0), W'(0));
    check("t5_cnt0",     W'(frame_cnt), W'(4));
    frame_q.push_back('{48, 8'h66});
    wait_beats("t5_wait", b0, 1, 50);
    check("t5_nbeats", W'(mon_q.size() - b0), W'(1));
    check("t5_data",   mon_q[b0].data, pat(45));
    check("t5_keep",   W'(mon_q[b0].keep), W'(64'h0000_FFFF_FFFF_FFFF));
    check("t5_last",   W'(mon_q[b0].last), W'(1));
    check("t5_tid",    W'(mon_q[b0].tid), W'(8'h66));
    check("t5_cnt",    W'(frame_cnt), W'(5));

    // 6: asynchronous reset mid-frame
    b0 = mon_q.size(); e0 = enb_cnt;
    frame_q.push_back('{512, 8'h77});
    wait_enb("t6_wait_enb", e0, 3, 50);
    #1 rst_n = 1'b0;
    #1;
    check("t6_enb",    W'(read_frame_enb), W'(0));
    check("t6_tvalid", W'(m_axis_tvalid), W'(0));
    check("t6_tlast",  W'(m_axis_tlast), W'(0));
    check("t6_tdata",  m_axis_tdata, W'(0));
    check("t6_cnt",    W'(frame_cnt), W'(0));
    nl = 0;
    for (int i = b0; i < mon_q.size(); i++) nl += int'(mon_q[i].last);
    check("t6_no_tlast", W'(nl), W'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b0 = mon_q.size();
    frame_q.push_back('{64, 8'h78});
    wait_beats("t6_wait", b0, 1, 50);
    repeat (10) @(posedge clk);
    #1;
    check("t6_nbeats", W'(mon_q.size() - b0), W'(1));
    check("t6_data",   mon_q[b0].data, pat(0));
    check("t6_keep",   W'(mon_q[b0].keep), W'(KEEP_ALL));
    check("t6_last",   W'(mon_q[b0].last), W'(1));
    check("t6_tid",    W'(mon_q[b0].tid), W'(8'h78));
    check("t6_cnt1",   W'(frame_cnt), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/c2h_frame_fetch.md
Name: c2h_frame_fetch

Overview:
Downstream consumer of the C2H frame-source read interface (read_frame_*).
- Pulls frames beat by beat with read_frame_enb.
- Compensates for the source's fixed data latency of FRAME_PIPELINE cycles.
- Re-packs frames as AXI-stream with tkeep/tlast/tid/tdest for the C2H DMA write engine.
- Owns backpressure: issues enb only when its skid FIFO can absorb every in-flight beat.

Parameters:
FRAME_DATA_WIDTH, 512, data width in bits; multiple of 8; BYTES = FRAME_DATA_WIDTH/8
LEN_WIDTH, 16, frame length field width (bytes)
TAG_WIDTH, 8, tag field width
FRAME_PIPELINE, 1, cycles from read_frame_enb to valid read_frame_tdata; legal 0..3
SKID_DEPTH, 8, skid FIFO entries; power of 2, >= FRAME_PIPELINE+2

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
read_frame_enb  out  1  beat read strobe to source
read_frame_tdata  in  FRAME_DATA_WIDTH  beat data, valid FRAME_PIPELINE cycles after enb
read_frame_ready  in  1  source has frame data; len/tag valid while high
read_frame_len  in  LEN_WIDTH  current frame length in bytes
read_frame_tag  in  TAG_WIDTH  current frame tag
m_axis_tdata  out  FRAME_DATA_WIDTH  output data
m_axis_tkeep  out  BYTES  byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last beat of frame
m_axis_tid  out  TAG_WIDTH  frame tag, every beat
m_axis_tdest  out  LEN_WIDTH  frame length, every beat
status_frame_done  out  1  one-cycle pulse when the tlast beat handshakes
status_len_err  out  1  one-cycle pulse on zero-length frame
frame_cnt  out  32  frames completed on m_axis; wraps at 2^32

Behaviour:
- Reset (rst_n low, async): all outputs 0, FSM IDLE, FIFO empty, pipeline valids cleared. Mid-frame reset drops in-flight beats and the partial frame; no tlast is emitted.
- FSM states: IDLE and FETCH.
- IDLE, read_frame_ready=1:
  - Latch len and tag.
  - Compute beats = ceil(len/BYTES) at LEN_WIDTH+1 bits.
  - Go to FETCH.
  - len==0: pulse status_len_err, treat as 1 beat, mark frame "discard".
- FETCH:
  - Assert enb when read_frame_ready && (fifo_count + inflight + 1 <= SKID_DEPTH).
  - inflight = popcount of the FRAME_PIPELINE-deep enb valid shift register.
  - Each enb decrements the remaining-beat counter.
  - The enb issuing the final beat returns the FSM to IDLE.
  - IDLE lasts at least 1 cycle, so back-to-back frames have a 1-cycle enb gap.
- read_frame_ready low in FETCH: enb held low, state kept, resume when it rises. len/tag are not resampled mid-frame.
- Metadata pipeline: per enb, carry {last, keep, tag, len, discard} through FRAME_PIPELINE register stages aligned with the data. At stage output, write {tdata, meta} into the FIFO unless discard. FRAME_PIPELINE=0: capture in the enb cycle.
- tkeep: non-last beats all ones. Last beat: rem = len % BYTES; rem==0 gives all ones, else the low rem bits set.
- FIFO never overflows by construction; overflow is an assertion failure.
- m_axis follows standard AXIS rules: data stable while tvalid && !tready.
- Zero-bubble throughput when tready=1 and SKID_DEPTH >= FRAME_PIPELINE+2.
- Latency: enb to m_axis_tvalid = FRAME_PIPELINE+1 cycles (FIFO write then registered read).
- status_frame_done and the frame_cnt increment occur in the cycle the tlast beat handshakes.

Decomposition:
- Package c2h_dma_pkg:
  - BYTES localparam.
  - Function beats_of(len) (ceil division).
  - Function last_keep(len) (keep mask).
  - Meta-word width constant.
- One sub-module: c2h_fetch_skid_fifo. Synchronous, first-word-fall-through, registered output, exposes count. Async active-low reset.

Test Plan:
1. PIPELINE=1, len=64, tag=0x05 -> exactly 1 enb; 1 beat, tlast=1, tkeep all 64 ones, tid=0x05, tdest=64; done pulse; frame_cnt=1.
2. len=130 -> 3 enb; 3 beats, tkeep of beat 3 = 0x3, tlast only on beat 3, tdest=130 on all beats.
3. tready=0, SKID_DEPTH=8, len=2048 (32 beats) -> enb stops after 8 outstanding beats; release tready -> 32 beats in order, data matches source counter pattern, no loss or duplication.
4. read_frame_ready dropped for 5 cycles mid-frame (len=512) -> enb low during the gap; 8 beats total, correct order, single tlast.
5. len=0 -> status_len_err pulse; one enb issued; no m_axis beat; next frame len=48 -> 1 beat, tkeep low 48 bits set.
6. rst_n asserted mid-frame (beat 3 of 8) -> outputs 0 asynchronously, enb low; after release, new frame len=64 emits a clean single beat and frame_cnt=1.
